// File: rtl/fifo_memoria.sv
// fifo_memoria: synchronous single-clock FIFO with registered read data,
// occupancy counter and sticky overflow/underflow flags.
//
// Handshake: this FIFO has no backpressure outputs; the requester watches
// lleno/vacio. A write is accepted on a rising edge when escribir=1 and
// (lleno=0 or a read is accepted on that same edge). A read is accepted when
// leer=1 and vacio=0, and its word appears on dato_s with valido_s=1 exactly
// one cycle later. Rejected requests change no data state and only raise the
// matching sticky flag (desborde for writes, subdesborde for reads).
module fifo_memoria #(
  parameter int ANCHO       = 8,
  parameter int PROFUNDIDAD = 16,
  parameter int DIR         = $clog2(PROFUNDIDAD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             escribir,
  input  logic [ANCHO-1:0] dato_e,
  input  logic             leer,
  output logic [ANCHO-1:0] dato_s,
  output logic             valido_s,
  output logic             lleno,
  output logic             vacio,
  output logic [DIR:0]     cuenta,
  output logic             desborde,
  output logic             subdesborde
);

  localparam logic [DIR:0] CUENTA_MAX = (DIR+1)'(PROFUNDIDAD);

  logic [ANCHO-1:0] mem_q [PROFUNDIDAD];
  logic [ANCHO-1:0] mem_d [PROFUNDIDAD];
  logic [DIR-1:0]   pe_q, pe_d;
  logic [DIR-1:0]   pl_q, pl_d;
  logic [DIR:0]     cuenta_q, cuenta_d;
  logic [ANCHO-1:0] dato_s_q, dato_s_d;
  logic             valido_q, valido_d;
  logic             desborde_q, desborde_d;
  logic             subdesborde_q, subdesborde_d;
  logic             rd_ok, wr_ok;

  // Status flags decode straight from the registered count.
  always_comb begin
    lleno = (cuenta_q == CUENTA_MAX);
    vacio = (cuenta_q == '0);
  end

  // Acceptance: a read frees a slot on the same edge, so a full FIFO can
  // still take a write when a read goes through alongside it.
  always_comb begin
    rd_ok = leer && !vacio;
    wr_ok = escribir && (!lleno || rd_ok);
  end

  // Next-state for pointers, count, read data and sticky flags.
  always_comb begin
    pe_d          = pe_q;
    pl_d          = pl_q;
    cuenta_d      = cuenta_q;
    dato_s_d      = dato_s_q;
    valido_d      = 1'b0;
    desborde_d    = desborde_q;
    subdesborde_d = subdesborde_q;

    // Pointers wrap naturally because they are exactly DIR bits wide.
    if (wr_ok) pe_d = pe_q + 1'b1;
    if (rd_ok) begin
      pl_d     = pl_q + 1'b1;
      dato_s_d = mem_q[pl_q];
      valido_d = 1'b1;
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   cuenta_d = cuenta_q + 1'b1;
      2'b01:   cuenta_d = cuenta_q - 1'b1;
      default: cuenta_d = cuenta_q;
    endcase

    if (escribir && !wr_ok) desborde_d    = 1'b1;
    if (leer && !rd_ok)     subdesborde_d = 1'b1;
  end

  // Next-state for the storage array: only the addressed word changes.
  always_comb begin
    for (int i = 0; i < PROFUNDIDAD; i++) mem_d[i] = mem_q[i];
    if (wr_ok) mem_d[pe_q] = dato_e;
  end

  // Control and output registers; reset wins over any request on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pe_q          <= '0;
      pl_q          <= '0;
      cuenta_q      <= '0;
      dato_s_q      <= '0;
      valido_q      <= 1'b0;
      desborde_q    <= 1'b0;
      subdesborde_q <= 1'b0;
    end else begin
      pe_q          <= pe_d;
      pl_q          <= pl_d;
      cuenta_q      <= cuenta_d;
      dato_s_q      <= dato_s_d;
      valido_q      <= valido_d;
      desborde_q    <= desborde_d;
      subdesborde_q <= subdesborde_d;
    end
  end

  // Storage array; contents are don't-care after reset because the count
  // and pointers gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PROFUNDIDAD; i++) mem_q[i] <= mem_d[i];
  end

  assign dato_s      = dato_s_q;
  assign valido_s    = valido_q;
  assign cuenta      = cuenta_q;
  assign desborde    = desborde_q;
  assign subdesborde = subdesborde_q;

endmodule

// File: tb/tb_fifo_memoria.sv
// Bench for fifo_memoria (ANCHO=8, PROFUNDIDAD=4): a reference queue model
// predicts every accepted read, and a monitor pops expected words as the
// FIFO presents them.
module tb_fifo_memoria;

  localparam int ANCHO = 8;
  localparam int PROF  = 4;
  localparam int DIR   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             escribir = 1'b0;
  logic [ANCHO-1:0] dato_e = '0;
  logic             leer = 1'b0;
  logic [ANCHO-1:0] dato_s;
  logic             valido_s;
  logic             lleno;
  logic             vacio;
  logic [DIR:0]     cuenta;
  logic             desborde;
  logic             subdesborde;

  int checks   = 0;
  int failures = 0;

  logic [ANCHO-1:0] model_q[$];
  logic [ANCHO-1:0] exp_q[$];
  logic             pend_valid = 1'b0;
  logic             exp_v_q    = 1'b0;
  logic             mon_en     = 1'b0;

  fifo_memoria #(.ANCHO(ANCHO), .PROFUNDIDAD(PROF), .DIR(DIR)) dut (
    .clk        (clk),
    .rst        (rst),
    .escribir   (escribir),
    .dato_e     (dato_e),
    .leer       (leer),
    .dato_s     (dato_s),
    .valido_s   (valido_s),
    .lleno      (lleno),
    .vacio      (vacio),
    .cuenta     (cuenta),
    .desborde   (desborde),
    .subdesborde(subdesborde)
  );

  // Clock
  always #5 clk = ~clk;

  // Expected valido_s for the cycle following each edge.
  always @(posedge clk) exp_v_q <= rst ? 1'b0 : pend_valid;

  // Scoreboard monitor: checks valido_s every cycle and pops a word per pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [ANCHO-1:0] e;
      checks++;
      if (valido_s !== exp_v_q) begin
        failures++;
        $display("FAIL valido_s: got %b expected %b at %0t", valido_s, exp_v_q, $time);
      end
      if (valido_s === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_read: dato_s=%0d with nothing expected at %0t", dato_s, $time);
        end else begin
          e = exp_q.pop_front();
          if (dato_s !== e) begin
            failures++;
            $display("FAIL dato_s: got %0d expected %0d at %0t", dato_s, e, $time);
          end
        end
      end
    end
  end

  // Driver: one clock of requests; updates the model with the same acceptance rules.
  task automatic drive_cycle(input logic wr, input logic [ANCHO-1:0] din, input logic rd);
    bit rd_ok, wr_ok;
    rd_ok = rd && (model_q.size() != 0);
    wr_ok = wr && ((model_q.size() < PROF) || rd_ok);
    escribir = wr;
    dato_e   = din;
    leer     = rd;
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(din);
    pend_valid = rd_ok;
    @(posedge clk);
    #1;
    escribir   = 1'b0;
    leer       = 1'b0;
    pend_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input logic wr_during);
    rst = 1'b1;
    escribir = wr_during;
    leer = wr_during;
    dato_e = 8'hAA;
    pend_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    escribir = 1'b0;
    leer = 1'b0;
    model_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    mon_en = 1'b1;
    checks++;
    if (cuenta !== 3'd0 || vacio !== 1'b1 || lleno !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: cuenta=%0d vacio=%b lleno=%b expected 0/1/0", cuenta, vacio, lleno);
    end
    checks++;
    if (dato_s !== 8'd0 || desborde !== 1'b0 || subdesborde !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: dato_s=%0d desborde=%b subdesborde=%b expected 0/0/0",
               dato_s, desborde, subdesborde);
    end
  endtask

  task automatic test_fill_drain;
    drive_cycle(1'b1, 8'd10, 1'b0);
    drive_cycle(1'b1, 8'd20, 1'b0);
    drive_cycle(1'b1, 8'd30, 1'b0);
    drive_cycle(1'b1, 8'd40, 1'b0);
    checks++;
    if (lleno !== 1'b1 || cuenta !== 3'd4) begin
      failures++;
      $display("FAIL fill: lleno=%b cuenta=%0d expected 1/4", lleno, cuenta);
    end
    repeat (4) drive_cycle(1'b0, '0, 1'b1);
    idle(1);
    checks++;
    if (vacio !== 1'b1 || cuenta !== 3'd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: vacio=%b cuenta=%0d pending=%0d expected 1/0/0", vacio, cuenta, exp_q.size());
    end
  endtask

  task automatic test_overflow;
    drive_cycle(1'b1, 8'd10, 1'b0);
    drive_cycle(1'b1, 8'd20, 1'b0);
    drive_cycle(1'b1, 8'd30, 1'b0);
    drive_cycle(1'b1, 8'd40, 1'b0);
    drive_cycle(1'b1, 8'd99, 1'b0);
    checks++;
    if (desborde !== 1'b1 || cuenta !== 3'd4) begin
      failures++;
      $display("FAIL overflow: desborde=%b cuenta=%0d expected 1/4", desborde, cuenta);
    end
    repeat (4) drive_cycle(1'b0, '0, 1'b1);
    idle(2);
    checks++;
    if (vacio !== 1'b1 || exp_q.size() != 0 || desborde !== 1'b1) begin
      failures++;
      $display("FAIL overflow_drain: vacio=%b pending=%0d desborde=%b expected 1/0/1",
               vacio, exp_q.size(), desborde);
    end
  endtask

  task automatic test_underflow;
    checks++;
    if (subdesborde !== 1'b0) begin
      failures++;
      $display("FAIL underflow_pre: subdesborde=%b expected 0", subdesborde);
    end
    drive_cycle(1'b0, '0, 1'b1);
    idle(1);
    checks++;
    if (subdesborde !== 1'b1 || dato_s !== 8'd40 || cuenta !== 3'd0) begin
      failures++;
      $display("FAIL underflow: subdesborde=%b dato_s=%0d cuenta=%0d expected 1/40/0",
               subdesborde, dato_s, cuenta);
    end
  endtask

  task automatic test_wraparound;
    logic [ANCHO-1:0] d;
    do_reset(1'b0);
    drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      drive_cycle(1'b1, d, 1'b1);
      checks++;
      if (cuenta !== 3'd2) begin
        failures++;
        $display("FAIL wrap_count: step %0d cuenta=%0d expected 2", i, cuenta);
      end
    end
    repeat (2) drive_cycle(1'b0, '0, 1'b1);
    idle(1);
    checks++;
    if (vacio !== 1'b1 || exp_q.size() != 0 || subdesborde !== 1'b0 || desborde !== 1'b0) begin
      failures++;
      $display("FAIL wrap_end: vacio=%b pending=%0d subdesborde=%b desborde=%b expected 1/0/0/0",
               vacio, exp_q.size(), subdesborde, desborde);
    end
  endtask

  task automatic test_simultaneous;
    do_reset(1'b0);
    for (int i = 0; i < PROF; i++) drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    drive_cycle(1'b1, 8'd77, 1'b1);
    checks++;
    if (cuenta !== 3'd4 || lleno !== 1'b1 || desborde !== 1'b0) begin
      failures++;
      $display("FAIL simul_full: cuenta=%0d lleno=%b desborde=%b expected 4/1/0", cuenta, lleno, desborde);
    end
    repeat (4) drive_cycle(1'b0, '0, 1'b1);
    drive_cycle(1'b1, 8'd55, 1'b1);
    checks++;
    if (cuenta !== 3'd1 || subdesborde !== 1'b1 || vacio !== 1'b0) begin
      failures++;
      $display("FAIL simul_empty: cuenta=%0d subdesborde=%b vacio=%b expected 1/1/0",
               cuenta, subdesborde, vacio);
    end
    drive_cycle(1'b0, '0, 1'b1);
    idle(1);
    checks++;
    if (exp_q.size() != 0 || vacio !== 1'b1) begin
      failures++;
      $display("FAIL simul_drain: pending=%0d vacio=%b expected 0/1", exp_q.size(), vacio);
    end
  endtask

  task automatic test_reset_mid;
    drive_cycle(1'b1, 8'd11, 1'b0);
    drive_cycle(1'b1, 8'd22, 1'b0);
    do_reset(1'b1);
    checks++;
    if (cuenta !== 3'd0 || vacio !== 1'b1 || dato_s !== 8'd0 || subdesborde !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: cuenta=%0d vacio=%b dato_s=%0d subdesborde=%b expected 0/1/0/0",
               cuenta, vacio, dato_s, subdesborde);
    end
    drive_cycle(1'b0, '0, 1'b1);
    idle(1);
    checks++;
    if (subdesborde !== 1'b1 || dato_s !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_read: subdesborde=%b dato_s=%0d expected 1/0", subdesborde, dato_s);
    end
    drive_cycle(1'b1, 8'd33, 1'b0);
    drive_cycle(1'b0, '0, 1'b1);
    idle(1);
    checks++;
    if (exp_q.size() != 0 || vacio !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_new: pending=%0d vacio=%b expected 0/1", exp_q.size(), vacio);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wraparound();
    test_simultaneous();
    test_reset_mid();
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_pending: %0d words never produced, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
